// File: rtl/motor_seq_pkg.sv
// Shared types and sizing helpers for the single-button N-motor rotation sequencer.
package motor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DEAD   = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam int unsigned DEF_F_CLK_HZ      = 25_000_000;
  localparam int unsigned DEF_N_MOTORS      = 4;
  localparam int unsigned DEF_DB_MS         = 5;
  localparam int unsigned DEF_LONG_PRESS_MS = 1000;
  localparam int unsigned DEF_NORMAL_SECS   = 30;
  localparam int unsigned DEF_TEST_SECS     = 3;
  localparam int unsigned DEF_DEAD_MS       = 100;

  localparam int unsigned MS_PER_S      = 1000;
  localparam int unsigned HB_HALF_MS    = 250;  // 2 Hz heartbeat
  localparam int unsigned BLINK_HALF_MS = 500;  // 1 Hz run blink

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned width_of(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_click_classifier.sv
// Single push-button front end: 2-FF synchroniser, polarity normalise, debounce,
// and classification into one-cycle short-click (on release) and long-press (at threshold) pulses.
module btn_click_classifier
  import motor_seq_pkg::*;
#(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned DB_CYCLES   = 5,
  parameter int unsigned LONG_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_click,
  output logic o_long
);

  localparam logic        IDLE_LVL = ACTIVE_LOW;
  localparam int unsigned DB_W     = width_of(DB_CYCLES);
  localparam int unsigned LONG_W   = width_of(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

  logic              r_sync1, r_sync2;
  logic              r_db;
  logic [DB_W-1:0]   r_db_cnt;
  logic [LONG_W-1:0] r_hold_cnt;
  logic              r_long_done;
  logic              r_click, r_long;
  logic              w_level;

  assign w_level = r_sync2 ^ ACTIVE_LOW;  // 1 = pressed

  // NOTE: every register here is state, so all updates are non-blocking and all of them are reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= IDLE_LVL;
      r_sync2     <= IDLE_LVL;
      r_db        <= 1'b0;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_click     <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_click <= 1'b0;
      r_long  <= 1'b0;

      if (w_level != r_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_db     <= w_level;
          r_db_cnt <= '0;
          if (!w_level) begin
            r_click     <= !r_long_done;
            r_long_done <= 1'b0;
          end
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end

      // Hold time advances only while the raw level still agrees, so a long pulse
      // can never land in the same cycle as the release click.
      if (!r_db) begin
        r_hold_cnt <= '0;
      end else if (!r_long_done && w_level) begin
        if (r_hold_cnt == LONG_LAST) begin
          r_long      <= 1'b1;
          r_long_done <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + LONG_W'(1);
        end
      end
    end
  end

  assign o_click = r_click;
  assign o_long  = r_long;

endmodule

// File: rtl/motor_sequencer_n.sv
// N-channel motor rotation sequencer: one motor per slot in turn, break-before-make dead time,
// click to start/pause/resume, long press to abort. Outputs are registered.
module motor_sequencer_n
  import motor_seq_pkg::*;
#(
  parameter int unsigned F_CLK_HZ       = DEF_F_CLK_HZ,
  parameter int unsigned N_MOTORS       = DEF_N_MOTORS,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned DB_MS          = DEF_DB_MS,
  parameter int unsigned LONG_PRESS_MS  = DEF_LONG_PRESS_MS,
  parameter int unsigned NORMAL_SECS    = DEF_NORMAL_SECS,
  parameter int unsigned TEST_SECS      = DEF_TEST_SECS,
  parameter int unsigned DEAD_MS        = DEF_DEAD_MS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              btn_i,
  input  logic                              test_i,
  output logic [N_MOTORS-1:0]               motor_o,
  output logic [idx_width(N_MOTORS)-1:0]    active_idx_o,
  output logic                              running_o,
  output logic                              paused_o,
  output logic                              blink_o,
  output logic                              heartbeat_o
);

  localparam int unsigned CYC_PER_MS = F_CLK_HZ / MS_PER_S;
  localparam int unsigned PRE_W      = width_of(CYC_PER_MS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_MS - 1);

  localparam int unsigned NORMAL_MS = NORMAL_SECS * MS_PER_S;
  localparam int unsigned TEST_MS   = TEST_SECS * MS_PER_S;
  localparam int unsigned TMR_W     = width_of(max2(max2(NORMAL_MS, TEST_MS), DEAD_MS));
  localparam logic [TMR_W-1:0] NORMAL_LAST = TMR_W'(NORMAL_MS - 1);
  localparam logic [TMR_W-1:0] TEST_LAST   = TMR_W'(TEST_MS - 1);
  localparam logic [TMR_W-1:0] DEAD_LAST   = TMR_W'((DEAD_MS > 0) ? DEAD_MS - 1 : 0);

  localparam int unsigned IDX_W = idx_width(N_MOTORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MOTORS - 1);

  localparam int unsigned HB_W  = width_of(HB_HALF_MS - 1);
  localparam int unsigned BLK_W = width_of(BLINK_HALF_MS - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_HALF_MS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_MS - 1);

  logic                w_click, w_long, w_ms_tick;
  logic [PRE_W-1:0]    r_pre;
  logic                r_test_s1, r_test_s2;

  state_t              r_state, r_resume;
  logic [IDX_W-1:0]    r_idx;
  logic [TMR_W-1:0]    r_timer, r_slot_last;
  logic [N_MOTORS-1:0] r_motor;
  logic                r_running, r_paused;

  logic [HB_W-1:0]     r_hb_cnt;
  logic                r_hb;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_blk_ph, r_blink;

  logic [IDX_W-1:0]    w_idx_next;
  logic [N_MOTORS-1:0] w_motor_next, w_motor_cur;
  logic [TMR_W-1:0]    w_slot_last;

  btn_click_classifier #(
    .ACTIVE_LOW (BTN_ACTIVE_LOW),
    .DB_CYCLES  (DB_MS * CYC_PER_MS),
    .LONG_CYCLES(LONG_PRESS_MS * CYC_PER_MS)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (btn_i),
    .o_click(w_click),
    .o_long (w_long)
  );

  assign w_ms_tick    = (r_pre == PRE_LAST);
  assign w_idx_next   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
  assign w_motor_next = N_MOTORS'(1) << w_idx_next;
  assign w_motor_cur  = N_MOTORS'(1) << r_idx;
  assign w_slot_last  = r_test_s2 ? TEST_LAST : NORMAL_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_test_s1 <= 1'b0;
      r_test_s2 <= 1'b0;
    end else begin
      r_pre     <= w_ms_tick ? '0 : r_pre + PRE_W'(1);
      r_test_s1 <= test_i;
      r_test_s2 <= r_test_s1;
    end
  end

  // One timer serves both slot and dead phases; PAUSED simply stops it advancing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_resume    <= RUN;
      r_idx       <= '0;
      r_timer     <= '0;
      r_slot_last <= '0;
      r_motor     <= '0;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
    end else if (w_long) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_timer   <= '0;
      r_motor   <= '0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_click) begin
          r_state     <= RUN;
          r_idx       <= '0;
          r_timer     <= '0;
          r_slot_last <= w_slot_last;
          r_motor     <= N_MOTORS'(1);
          r_running   <= 1'b1;
        end
        RUN: if (w_click) begin
          r_state   <= PAUSED;
          r_resume  <= RUN;
          r_motor   <= '0;
          r_running <= 1'b0;
          r_paused  <= 1'b1;
        end else if (w_ms_tick) begin
          if (r_timer == r_slot_last) begin
            r_timer <= '0;
            if (DEAD_MS == 0) begin
              r_idx       <= w_idx_next;
              r_slot_last <= w_slot_last;
              r_motor     <= w_motor_next;
            end else begin
              r_state <= DEAD;
              r_motor <= '0;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        DEAD: if (w_click) begin
          r_state   <= PAUSED;
          r_resume  <= DEAD;
          r_running <= 1'b0;
          r_paused  <= 1'b1;
        end else if (w_ms_tick) begin
          if (r_timer == DEAD_LAST) begin
            r_state     <= RUN;
            r_idx       <= w_idx_next;
            r_timer     <= '0;
            r_slot_last <= w_slot_last;
            r_motor     <= w_motor_next;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        PAUSED: if (w_click) begin
          r_state   <= r_resume;
          r_running <= 1'b1;
          r_paused  <= 1'b0;
          if (r_resume == RUN) r_motor <= w_motor_cur;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Heartbeat is free-running; blink phase is held at 0 in IDLE and frozen while paused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hb_cnt  <= '0;
      r_hb      <= 1'b0;
      r_blk_cnt <= '0;
      r_blk_ph  <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      if (w_ms_tick) begin
        if (r_hb_cnt == HB_LAST) begin
          r_hb_cnt <= '0;
          r_hb     <= ~r_hb;
        end else begin
          r_hb_cnt <= r_hb_cnt + HB_W'(1);
        end
      end
      if (r_state == IDLE) begin
        r_blk_cnt <= '0;
        r_blk_ph  <= 1'b0;
      end else if (w_ms_tick && r_running) begin
        if (r_blk_cnt == BLK_LAST) begin
          r_blk_cnt <= '0;
          r_blk_ph  <= ~r_blk_ph;
        end else begin
          r_blk_cnt <= r_blk_cnt + BLK_W'(1);
        end
      end
      r_blink <= r_paused | (r_running & r_blk_ph);
    end
  end

  assign motor_o      = r_motor;
  assign active_idx_o = r_idx;
  assign running_o    = r_running;
  assign paused_o     = r_paused;
  assign blink_o      = r_blink;
  assign heartbeat_o  = r_hb;

endmodule

// File: tb/tb_motor_sequencer_n.sv
// Directed bench for motor_sequencer_n at 10 kHz (10 cycles per ms), 3 motors, 1 s test slots, 5 ms dead time.
module tb_motor_sequencer_n;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       btn_i  = 1'b1;
  logic       test_i = 1'b1;
  logic [2:0] motor_o;
  logic [1:0] active_idx_o;
  logic       running_o, paused_o, blink_o, heartbeat_o;

  int n_total = 0;
  int n_bad   = 0;
  int n, d, run_a;

  always #5 clk = ~clk;

  motor_sequencer_n #(
    .F_CLK_HZ      (10_000),
    .N_MOTORS      (3),
    .BTN_ACTIVE_LOW(1'b1),
    .DB_MS         (1),
    .LONG_PRESS_MS (20),
    .NORMAL_SECS   (30),
    .TEST_SECS     (1),
    .DEAD_MS       (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn_i),
    .test_i      (test_i),
    .motor_o     (motor_o),
    .active_idx_o(active_idx_o),
    .running_o   (running_o),
    .paused_o    (paused_o),
    .blink_o     (blink_o),
    .heartbeat_o (heartbeat_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic cyc(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    btn_i = 1'b0;
    cyc(hold);
    btn_i = 1'b1;
  endtask

  // Count edges until motor_o leaves from_val; an expired bound is a failed comparison.
  task automatic wait_motor(input string tag, input logic [2:0] from_val, input int bound,
                            output int cnt);
    cnt = 0;
    while (motor_o === from_val && cnt < bound) begin
      cyc(1);
      cnt++;
    end
    check({tag, " within bound"}, 32'(cnt < bound), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " motor_o"},      32'(motor_o),      32'd0);
    check({tag, " active_idx_o"}, 32'(active_idx_o), 32'd0);
    check({tag, " running_o"},    32'(running_o),    32'd0);
    check({tag, " paused_o"},     32'(paused_o),     32'd0);
    check({tag, " blink_o"},      32'(blink_o),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(3);
    check_idle_outputs("reset");
    check("reset heartbeat_o", 32'(heartbeat_o), 32'd0);
    rst_n = 1'b1;

    // Heartbeat toggles every 250 ms (2500 cycles) from reset release
    cyc(1000);
    check("heartbeat low at 100ms", 32'(heartbeat_o), 32'd0);
    cyc(2000);
    check("heartbeat high at 300ms", 32'(heartbeat_o), 32'd1);

    // Short press starts motor 0 on release; no action on the press itself
    press(50);
    check("no start while pressed", 32'(motor_o), 32'd0);
    wait_motor("start", 3'b000, 40, n);
    check($sformatf("start latency %0d in 11..15", n), 32'(n >= 11 && n <= 15), 32'd1);
    check("start motor_o", 32'(motor_o), 32'b001);
    check("start idx", 32'(active_idx_o), 32'd0);
    check("start running_o", 32'(running_o), 32'd1);
    check("start paused_o", 32'(paused_o), 32'd0);

    // First slot: blink phase starts at 0, toggles at 500 ms; test_i dropped mid-slot
    cyc(10);
    check("blink low early in run", 32'(blink_o), 32'd0);
    cyc(5990);
    check("blink high at 600ms", 32'(blink_o), 32'd1);
    test_i = 1'b0;
    wait_motor("slot0 end", 3'b001, 5000, n);
    d = 6000 + n;
    check($sformatf("slot0 length %0d in 9990..10000", d), 32'(d >= 9990 && d <= 10000), 32'd1);
    check("dead motor_o", 32'(motor_o), 32'd0);
    check("dead running_o", 32'(running_o), 32'd1);
    check("dead idx held", 32'(active_idx_o), 32'd0);
    test_i = 1'b1;
    wait_motor("dead0", 3'b000, 100, n);
    check("dead0 length", 32'(n), 32'd50);
    check("slot1 motor_o", 32'(motor_o), 32'b010);
    check("slot1 idx", 32'(active_idx_o), 32'd1);

    wait_motor("slot1 end", 3'b010, 10100, n);
    check($sformatf("slot1 length %0d in 9990..10000", n), 32'(n >= 9990 && n <= 10000), 32'd1);
    wait_motor("dead1", 3'b000, 100, n);
    check("slot2 motor_o", 32'(motor_o), 32'b100);
    check("slot2 idx", 32'(active_idx_o), 32'd2);
    wait_motor("slot2 end", 3'b100, 10100, n);
    wait_motor("dead2", 3'b000, 100, n);
    check("wrap motor_o", 32'(motor_o), 32'b001);
    check("wrap idx", 32'(active_idx_o), 32'd0);

    // Pause 400 ms into the slot, hold 2 s, resume with the remainder intact
    cyc(4000);
    press(50);
    wait_motor("pause", 3'b001, 40, n);
    run_a = 4050 + n;
    cyc(2);
    check("paused paused_o", 32'(paused_o), 32'd1);
    check("paused blink_o", 32'(blink_o), 32'd1);
    check("paused running_o", 32'(running_o), 32'd0);
    check("paused idx", 32'(active_idx_o), 32'd0);
    cyc(20000);
    check("still paused after 2s", 32'(paused_o), 32'd1);
    check("motor off after 2s pause", 32'(motor_o), 32'd0);
    press(50);
    wait_motor("resume", 3'b000, 40, n);
    check("resume motor_o", 32'(motor_o), 32'b001);
    check("resume paused_o", 32'(paused_o), 32'd0);
    check("resume running_o", 32'(running_o), 32'd1);
    wait_motor("resumed slot end", 3'b001, 10100, n);
    d = run_a + n;
    check($sformatf("paused slot run total %0d in 9975..10015", d), 32'(d >= 9975 && d <= 10015), 32'd1);
    wait_motor("dead after resume", 3'b000, 100, n);
    check("after resume motor_o", 32'(motor_o), 32'b010);

    // Long press during RUN aborts at the 20 ms mark while still held
    cyc(100);
    btn_i = 1'b0;
    cyc(150);
    check("running before long threshold", 32'(motor_o), 32'b010);
    cyc(80);
    check_idle_outputs("long abort");
    btn_i = 1'b1;
    cyc(100);
    check("no restart after long release motor_o", 32'(motor_o), 32'd0);
    check("no restart after long release running_o", 32'(running_o), 32'd0);

    // Contact bounce shorter than the debounce window is ignored
    for (int i = 0; i < 10; i++) begin
      #3 btn_i = ~btn_i;
    end
    btn_i = 1'b1;
    cyc(50);
    check("bounce ignored motor_o", 32'(motor_o), 32'd0);
    check("bounce ignored running_o", 32'(running_o), 32'd0);

    // Reset for one edge in the middle of a dead gap
    press(50);
    wait_motor("restart", 3'b000, 40, n);
    check("restart motor_o", 32'(motor_o), 32'b001);
    wait_motor("slot before reset", 3'b001, 10100, n);
    cyc(20);
    check("in dead before reset", 32'(running_o), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    check_idle_outputs("mid-dead reset");
    check("mid-dead reset heartbeat_o", 32'(heartbeat_o), 32'd0);
    rst_n = 1'b1;
    cyc(20);
    press(50);
    wait_motor("post-reset start", 3'b000, 40, n);
    check("post-reset motor_o", 32'(motor_o), 32'b001);
    check("post-reset idx", 32'(active_idx_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
